mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences a single-ported RAM between the instruction and data caches of CPUS cores.
- Sits between the per-core icache/dcache request ports and the RAM model.
- Grants one word transaction at a time.
- Priority: dcache over icache; round-robin between cores within each class.

Parameters:
- CPUS, 2, number of cores; each core has one icache and one dcache port.
- STARVE_LIMIT, 4, completed grants an icache may lose before promotion; used only with ARB_STARVE_GUARD_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  icache read request per core.
- iaddr  in  CPUS*32  icache word address per core.
- iwait  out  CPUS  icache wait; 0 only in the completion cycle.
- iload  out  CPUS*32  icache read data per core.
- dREN  in  CPUS  dcache read request per core.
- dWEN  in  CPUS  dcache write request per core.
- daddr  in  CPUS*32  dcache word address per core.
- dstore  in  CPUS*32  dcache write data per core.
- dwait  out  CPUS  dcache wait; 0 only in the completion cycle.
- dload  out  CPUS*32  dcache read data per core.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, all iwait=1, all dwait=1. State is ARB, grant is invalid, RR pointers are 0.
- iload[c] and dload[c] always equal ramload for every c. Data is valid only when the matching wait is 0.
- State ARB:
  - RAM enables are 0.
  - If any dREN|dWEN is set, latch a dcache grant. Search starts at the dcache RR pointer and wraps modulo CPUS.
  - Otherwise, if any iREN is set, latch an icache grant using the icache RR pointer.
  - When a grant is latched, next state is XFER. With no request, stay in ARB.
- State XFER:
  - RAM signals are driven combinationally from the granted port's live inputs: ramaddr, ramstore, ramREN, ramWEN.
  - For a dcache grant, dWEN has precedence: if dREN and dWEN are both 1, then ramWEN=1 and ramREN=0.
  - ramstate==ACCESS: the granted wait goes to 0 for exactly this cycle. The class RR pointer becomes (granted core+1) mod CPUS. Next state is ARB.
  - ramstate FREE, BUSY or ERROR: stay in XFER and keep the wait at 1. ERROR is retried indefinitely.
  - If the granted requester drops its enables: abort, ram enables go to 0 that cycle, next state is ARB, no pointer update, and no wait goes low.
- Latency: minimum 2 cycles from request assertion to wait low (1 ARB cycle, then XFER with immediate ACCESS).
- No request can complete while another is in XFER. Every non-granted wait stays 1.
- A dcache two-word block fetch consists of two independent grants. Another core's dcache may interleave between the words; the caches tolerate this.
- An address change by the granted requester during XFER is forwarded to the RAM without regranting.
- Asynchronous reset mid-XFER: enables drop to 0 immediately, state goes to ARB, and the in-flight word is discarded.

Optional Feature:
- ARB_STARVE_GUARD_EN defined:
  - Each core keeps a 3-bit starvation counter.
  - The counter increments when a grant completes while that core's iREN is 1 and the core was not granted.
  - It clears when that core's icache completes.
  - In ARB, a core whose counter is >= STARVE_LIMIT wins over all dcache requests. Ties go to the lowest core index.
- Undefined: no counters; strict dcache-over-icache priority. Indefinite icache starvation is permitted.

Test Plan:
- Reset: hold nRST=0 → ramREN=ramWEN=0, iwait=2'b11, dwait=2'b11. Release nRST with no requests → RAM enables stay 0.
- Single icache read: core0 sets iREN, iaddr=0x40; RAM returns ACCESS with ramload=0x1234 on the first XFER cycle → iwait[0]=0 exactly 2 cycles after the request, iload[0]=0x1234, ramREN=1 in that cycle only.
- Priority: core0 iREN and core1 dWEN asserted together, daddr=0x80, dstore=0xCAFE → core1 granted first (ramWEN=1, ramaddr=0x80, ramstore=0xCAFE); core0 completes on a later grant.
- Round-robin: both cores hold dREN for 4 transactions, RAM ACCESS immediate → completion order 0,1,0,1.
- Abort/stall: core0 dREN granted, ramstate=BUSY for 3 cycles, then core0 drops dREN → no wait pulse, next grant goes to core0 iREN. Separately, ERROR for 5 cycles then ACCESS → completion only on the ACCESS cycle.
- ARB_STARVE_GUARD_EN with STARVE_LIMIT=4: core1 iREN held while core0 dREN is continuous → core1 icache is granted after exactly 4 core0 completions.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of per-core icache/dcache request ports and the single RAM port
// shared through mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned CPUS = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;

  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] dload;

  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [31:0]           ramload;
  logic [1:0]            ramstate;

  // Arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Cache/RAM environment view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter for CPUS cores: dcache over icache, round-robin per class.
// Optional icache starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned CPUS = 2
`ifdef ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CW         = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0]  RAM_ACCESS = 2'd2;

  typedef enum logic {ARB, XFER} state_e;

  state_e          state_q, state_d;
  logic            gnt_is_d_q, gnt_is_d_d;
  logic [CW-1:0]   gnt_core_q, gnt_core_d;
  logic [CW-1:0]   d_rr_q, d_rr_d;
  logic [CW-1:0]   i_rr_q, i_rr_d;

  logic [CPUS-1:0] d_req;
  logic            d_hit, i_hit;
  logic [CW-1:0]   d_pick, i_pick;
  logic            promo_hit;
  logic [CW-1:0]   promo_pick;
  logic            g_active;
  logic [CW-1:0]   rr_next;

  // Granted requester still holding its enables
  assign g_active = gnt_is_d_q ? (bus.dREN[gnt_core_q] | bus.dWEN[gnt_core_q])
                               : bus.iREN[gnt_core_q];
  assign rr_next  = CW'((32'(gnt_core_q) + 32'd1) % CPUS);

  // Read data is broadcast; each cache qualifies it with its own wait
  always_comb begin : load_fanout
    for (int unsigned c = 0; c < CPUS; c++) begin
      bus.iload[CW'(c)] = bus.ramload;
      bus.dload[CW'(c)] = bus.ramload;
    end
  end

  // Round-robin search per class, starting at the class pointer and wrapping
  always_comb begin : rr_search
    int unsigned idx;
    idx    = 0;
    d_req  = bus.dREN | bus.dWEN;
    d_hit  = 1'b0;
    i_hit  = 1'b0;
    d_pick = '0;
    i_pick = '0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      idx = (32'(d_rr_q) + k) % CPUS;
      if (!d_hit && d_req[CW'(idx)]) begin
        d_hit  = 1'b1;
        d_pick = CW'(idx);
      end
      idx = (32'(i_rr_q) + k) % CPUS;
      if (!i_hit && bus.iREN[CW'(idx)]) begin
        i_hit  = 1'b1;
        i_pick = CW'(idx);
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [CPUS-1:0][2:0] starve_q, starve_d;
  logic                 xfer_done;

  assign xfer_done = (state_q == XFER) && g_active && (bus.ramstate == RAM_ACCESS);

  // Count grants an icache sat through while requesting; clear on its own completion
  always_comb begin : starve_next
    for (int unsigned c = 0; c < CPUS; c++) begin
      starve_d[CW'(c)] = starve_q[CW'(c)];
      if (xfer_done) begin
        if (!gnt_is_d_q && (gnt_core_q == CW'(c))) begin
          starve_d[CW'(c)] = '0;
        end else if (bus.iREN[CW'(c)] && (starve_q[CW'(c)] != 3'd7)) begin
          starve_d[CW'(c)] = starve_q[CW'(c)] + 3'd1;
        end
      end
    end
  end

  // Lowest-index starved icache overrides every dcache request
  always_comb begin : promo_search
    promo_hit  = 1'b0;
    promo_pick = '0;
    for (int unsigned c = 0; c < CPUS; c++) begin
      if (!promo_hit && bus.iREN[CW'(c)] && (32'(starve_q[CW'(c)]) >= STARVE_LIMIT)) begin
        promo_hit  = 1'b1;
        promo_pick = CW'(c);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin : starve_reg
    if (!nRST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign promo_hit  = 1'b0;
  assign promo_pick = '0;
`endif

  // Next state, grant latch and RAM/wait outputs
  always_comb begin : fsm_comb
    state_d      = state_q;
    gnt_is_d_d   = gnt_is_d_q;
    gnt_core_d   = gnt_core_q;
    d_rr_d       = d_rr_q;
    i_rr_d       = i_rr_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = '1;
    bus.dwait    = '1;

    case (state_q)
      ARB: begin
        if (promo_hit) begin
          gnt_is_d_d = 1'b0;
          gnt_core_d = promo_pick;
          state_d    = XFER;
        end else if (d_hit) begin
          gnt_is_d_d = 1'b1;
          gnt_core_d = d_pick;
          state_d    = XFER;
        end else if (i_hit) begin
          gnt_is_d_d = 1'b0;
          gnt_core_d = i_pick;
          state_d    = XFER;
        end
      end

      XFER: begin
        if (!g_active) begin
          state_d = ARB;
        end else begin
          if (gnt_is_d_q) begin
            // A write wins when a dcache raises both enables
            bus.ramWEN   = bus.dWEN[gnt_core_q];
            bus.ramREN   = bus.dREN[gnt_core_q] & ~bus.dWEN[gnt_core_q];
            bus.ramaddr  = bus.daddr[gnt_core_q];
            bus.ramstore = bus.dstore[gnt_core_q];
          end else begin
            bus.ramREN   = 1'b1;
            bus.ramaddr  = bus.iaddr[gnt_core_q];
          end
          if (bus.ramstate == RAM_ACCESS) begin
            state_d = ARB;
            if (gnt_is_d_q) begin
              bus.dwait[gnt_core_q] = 1'b0;
              d_rr_d                = rr_next;
            end else begin
              bus.iwait[gnt_core_q] = 1'b0;
              i_rr_d                = rr_next;
            end
          end
        end
      end

      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin : state_reg
    if (!nRST) begin
      state_q    <= ARB;
      gnt_is_d_q <= 1'b0;
      gnt_core_q <= '0;
      d_rr_q     <= '0;
      i_rr_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_is_d_q <= gnt_is_d_d;
      gnt_core_q <= gnt_core_d;
      d_rr_q     <= d_rr_d;
      i_rr_q     <= i_rr_d;
    end
  end

endmodule
